// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg: shared types and constants for the mem_rd_stream read initiator.
//   state_e      - transfer FSM encoding (IDLE, RUN, DRAIN, DONE)
//   BUF_DEPTH    - depth of the output skid buffer
//   BUF_CNT_BIT  - width of the buffer occupancy count
package mem_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int unsigned BUF_DEPTH   = 2;
  localparam int unsigned BUF_CNT_BIT = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/mem_rd_buf.sv
// mem_rd_buf: 2-entry synchronous FIFO with a registered head entry.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   push_i        - write push_data_i (accepted when not full, or full with pop)
//   push_data_i   - data to enqueue
//   pop_i         - dequeue head (ignored when empty)
//   head_o        - head entry, straight from a register
//   valid_o       - FIFO non-empty
//   count_o       - current occupancy
module mem_rd_buf
  import mem_rd_pkg::*;
#(
  parameter int unsigned DATA_BIT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [DATA_BIT-1:0]    push_data_i,
  input  logic                   pop_i,
  output logic [DATA_BIT-1:0]    head_o,
  output logic                   valid_o,
  output logic [BUF_CNT_BIT-1:0] count_o
);

  localparam logic [BUF_CNT_BIT-1:0] CNT_FULL = BUF_CNT_BIT'(BUF_DEPTH);
  localparam logic [BUF_CNT_BIT-1:0] CNT_ONE  = BUF_CNT_BIT'(1);

  logic [DATA_BIT-1:0]    head_q, head_d;
  logic [DATA_BIT-1:0]    tail_q, tail_d;
  logic [BUF_CNT_BIT-1:0] count_q, count_d;
  logic                   pop_ok, push_ok;

  always_comb begin
    pop_ok  = pop_i && (count_q != '0);
    push_ok = push_i && ((count_q != CNT_FULL) || pop_ok);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == '0) head_d = push_data_i;
        else               tail_d = push_data_i;
        count_d = count_q + CNT_ONE;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - CNT_ONE;
      end
      2'b11: begin
        // Occupancy unchanged; with one entry the new word becomes the head,
        // with two the tail shifts up and the new word takes its place.
        if (count_q == CNT_ONE) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/mem_rd_stream.sv
// mem_rd_stream: read initiator for a single-cycle-latency SRAM read port.
// On start it walks len words from base_addr (wrapping modulo DEPTH), issues
// reads, and presents returned words on a valid/ready stream with out_last on
// the final word and a one-cycle done pulse after the last handshake.
// Optional build macro MEM_RD_STREAM_STRIDE_EN adds a stride input latched on
// start; the address then advances by stride instead of 1.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, base_addr, len    - command (sampled only while busy=0)
//   stride                   - address increment (MEM_RD_STREAM_STRIDE_EN only)
//   busy, done               - status
//   mem_raddr, mem_ren       - SRAM read request
//   mem_rdata                - SRAM read data, valid the cycle after mem_ren
//   out_data, out_valid,
//   out_ready, out_last      - output stream
module mem_rd_stream
  import mem_rd_pkg::*;
#(
  parameter int unsigned DATA_BIT = 64,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_BIT = $clog2(DEPTH),
  parameter int unsigned LEN_BIT  = ADDR_BIT + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_BIT-1:0] base_addr,
  input  logic [LEN_BIT-1:0]  len,
`ifdef MEM_RD_STREAM_STRIDE_EN
  input  logic [ADDR_BIT-1:0] stride,
`endif
  output logic                busy,
  output logic                done,
  output logic [ADDR_BIT-1:0] mem_raddr,
  output logic                mem_ren,
  input  logic [DATA_BIT-1:0] mem_rdata,
  output logic [DATA_BIT-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam logic [ADDR_BIT:0]  DEPTH_W = (ADDR_BIT + 1)'(DEPTH);
  localparam logic [LEN_BIT-1:0] LEN_ONE = LEN_BIT'(1);

  state_e                 state_q, state_d;
  logic [LEN_BIT-1:0]     len_q;
  logic [LEN_BIT-1:0]     issued_q;
  logic [LEN_BIT-1:0]     sent_q, sent_d;
  logic [ADDR_BIT-1:0]    addr_q, addr_next;
  logic [ADDR_BIT-1:0]    step;
  logic [ADDR_BIT:0]      addr_sum;
  logic                   inflight_q;
  logic                   pop;
  logic                   accept;
  logic [BUF_CNT_BIT-1:0] buf_count;
  logic [BUF_CNT_BIT:0]   occ;

`ifdef MEM_RD_STREAM_STRIDE_EN
  logic [ADDR_BIT-1:0] step_q;

  always_ff @(posedge clk) begin
    if (rst)         step_q <= '0;
    else if (accept) step_q <= stride;
  end

  assign step = step_q;
`else
  assign step = ADDR_BIT'(1);
`endif

  mem_rd_buf #(
    .DATA_BIT (DATA_BIT)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (mem_rdata),
    .pop_i       (pop),
    .head_o      (out_data),
    .valid_o     (out_valid),
    .count_o     (buf_count)
  );

  assign pop    = out_valid && out_ready;
  assign accept = (state_q == ST_IDLE) && start;

  // Credit check counts the word already in flight and frees the slot being
  // popped this cycle, so full rate is kept with a 2-entry buffer.
  assign occ     = {1'b0, buf_count} + {{BUF_CNT_BIT{1'b0}}, inflight_q}
                 - {{BUF_CNT_BIT{1'b0}}, pop};
  assign mem_ren = (state_q == ST_RUN) && (issued_q < len_q)
                && (occ < (BUF_CNT_BIT + 1)'(BUF_DEPTH));
  assign mem_raddr = addr_q;

  // Modulo-DEPTH accumulate; valid for any DEPTH as both operands are < DEPTH.
  always_comb begin
    addr_sum = {1'b0, addr_q} + {1'b0, step};
    if (addr_sum >= DEPTH_W) addr_sum = addr_sum - DEPTH_W;
    addr_next = addr_sum[ADDR_BIT-1:0];
  end

  always_comb begin
    sent_d = sent_q;
    if (pop && (sent_q < len_q)) sent_d = sent_q + LEN_ONE;
  end

  assign out_last = out_valid && (sent_q == (len_q - LEN_ONE));

  always_comb begin
    state_d = state_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (issued_q == len_q) state_d = ST_DRAIN;
      // Looking at sent_d lets done follow the final handshake directly.
      ST_DRAIN: if (sent_d == len_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= mem_ren;
      if (accept) begin
        len_q    <= len;
        addr_q   <= base_addr;
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (mem_ren) begin
          issued_q <= issued_q + LEN_ONE;
          addr_q   <= addr_next;
        end
        sent_q <= sent_d;
      end
    end
  end

endmodule

// File: tb/tb_mem_rd_stream.sv
module tb_mem_rd_stream;

  localparam int unsigned DATA_BIT = 64;
  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned ADDR_BIT = 10;
  localparam int unsigned LEN_BIT  = 11;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [ADDR_BIT-1:0] base_addr = '0;
  logic [LEN_BIT-1:0]  len = '0;
  logic [ADDR_BIT-1:0] stride = ADDR_BIT'(1);
  logic                busy, done, mem_ren, out_valid, out_last;
  logic                out_ready = 1'b0;
  logic [ADDR_BIT-1:0] mem_raddr;
  logic [DATA_BIT-1:0] mem_rdata = '0;
  logic [DATA_BIT-1:0] out_data;

  always #5 clk = ~clk;

  mem_rd_stream #(
    .DATA_BIT (DATA_BIT),
    .DEPTH    (DEPTH),
    .ADDR_BIT (ADDR_BIT),
    .LEN_BIT  (LEN_BIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
`ifdef MEM_RD_STREAM_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .mem_raddr (mem_raddr),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  function automatic logic [63:0] mem_word(input int unsigned a);
    logic [31:0] hi, lo;
    hi = a * 32'h9E37_79B1;
    lo = a ^ 32'hA5A5_0000;
    return {hi, lo};
  endfunction

  // SRAM model: registered read, one cycle after mem_ren.
  always @(posedge clk) if (mem_ren) mem_rdata <= mem_word(int'(mem_raddr));

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned exp_addr[$];

  int vectors = 0;
  int miscompares = 0;
  int rens, pops, dones, first_ren, first_valid, done_cyc, busy_cycles;
  logic        stall_prev;
  logic [63:0] prev_data;
  logic        prev_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_run();
    rens = 0; pops = 0; dones = 0; first_ren = -1; first_valid = -1;
    done_cyc = -1; busy_cycles = 0; stall_prev = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    exp_q.delete(); exp_addr.delete();
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_mem_ren"}, mem_ren, 0);
    check({pfx, "_mem_raddr"}, mem_raddr, 0);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_last"}, out_last, 0);
    check({pfx, "_out_data"}, out_data, 0);
  endtask

  // One clock cycle: sample at negedge, then advance to just after posedge.
  task automatic step_cycle(input int n);
    exp_t e;
    @(negedge clk);
    if (mem_ren) begin
      rens++;
      if (first_ren < 0) first_ren = n;
      check("ren_expected", exp_addr.size() > 0, 1);
      if (exp_addr.size() > 0) check("mem_raddr", mem_raddr, exp_addr.pop_front());
    end
    if (out_valid && first_valid < 0) first_valid = n;
    if (stall_prev) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, prev_data);
      check("stall_last", out_last, prev_last);
    end
    if (out_valid && out_ready) begin
      pops++;
      check("pop_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", out_last, e.last);
      end
    end
    check("outstanding_le2", (rens - pops) <= 2, 1);
    if (done) begin
      dones++;
      done_cyc = n;
    end
    if (busy) busy_cycles++;
    stall_prev = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    @(posedge clk);
    #1;
  endtask

  task automatic load_expect(input int unsigned b, input int unsigned l, input int unsigned s);
    int unsigned a;
    exp_t e;
    for (int unsigned k = 0; k < l; k++) begin
      a = (b + k * s) % DEPTH;
      exp_addr.push_back(a);
      e.data = mem_word(a);
      e.last = (k == l - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_xfer(input string name, input int unsigned b, input int unsigned l,
                          input int unsigned s, input logic [3:0] pat, input int hold,
                          input int x_ren, input int x_valid, input int x_done);
    clear_run();
    load_expect(b, l, s);
    base_addr = ADDR_BIT'(b);
    len       = LEN_BIT'(l);
    stride    = ADDR_BIT'(s);
    start     = 1'b1;
    out_ready = pat[0];
    step_cycle(0);
    for (int n = 1; n < 400 && dones == 0; n++) begin
      start = (n < hold);
      if (start) base_addr = ADDR_BIT'(b + 7);
      out_ready = pat[n % 4];
      step_cycle(n);
    end
    start = 1'b0;
    check({name, "_done_count"}, dones, 1);
    check({name, "_ren_count"}, rens, l);
    check({name, "_pop_count"}, pops, l);
    check({name, "_sb_empty"}, exp_q.size(), 0);
    check({name, "_busy_cycles"}, busy_cycles, done_cyc);
    if (x_ren >= 0)   check({name, "_first_ren"}, first_ren, x_ren);
    if (x_valid >= 0) check({name, "_first_valid"}, first_valid, x_valid);
    if (x_done >= 0)  check({name, "_done_cycle"}, done_cyc, x_done);
    step_cycle(400);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_done"}, done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_xfer("basic", 10, 4, 1, 4'b1111, 1, 1, 3, 7);
    run_xfer("wrap", 1022, 4, 1, 4'b1111, 1, 1, 3, 7);
    run_xfer("bp", 200, 8, 1, 4'b1001, 3, 1, 3, -1);
    run_xfer("len0", 50, 0, 1, 4'b1111, 1, -1, -1, 1);

    // Reset in the middle of an 8-word transfer after 3 words are out.
    clear_run();
    load_expect(100, 8, 1);
    base_addr = ADDR_BIT'(100);
    len = LEN_BIT'(8);
    start = 1'b1;
    out_ready = 1'b1;
    step_cycle(0);
    start = 1'b0;
    for (int n = 1; n < 50 && pops < 3; n++) step_cycle(n);
    check("mid_pops", pops, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("midrst");
    dones = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) dones++;
      check("midrst_quiet_valid", out_valid, 0);
      check("midrst_quiet_ren", mem_ren, 0);
    end
    check("midrst_no_done", dones, 0);
    @(posedge clk);
    #1;

    run_xfer("after_rst", 0, 2, 1, 4'b1111, 1, 1, 3, 5);

`ifdef MEM_RD_STREAM_STRIDE_EN
    run_xfer("stride", 5, 3, 3, 4'b1111, 1, 1, 3, 6);
    run_xfer("stride0", 77, 3, 0, 4'b1001, 1, 1, 3, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
